// File: rtl/ysyx_22050243_lsu_pkg.sv
// Shared LSU definitions: access size encodings, store-align FSM states,
// bus strobe width and small size-decoding helpers.
package ysyx_22050243_lsu_pkg;

    localparam int BUS_W  = 64;
    localparam int STRB_W = BUS_W / 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    // Byte-enable pattern of an access of this size starting at lane 0.
    function automatic logic [STRB_W-1:0] size_strb(input logic [1:0] size);
        case (size_e'(size))
            SZ_B:    size_strb = 8'h01;
            SZ_H:    size_strb = 8'h03;
            SZ_W:    size_strb = 8'h0F;
            default: size_strb = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size_e'(size))
            SZ_B:    align_mask = 3'b000;
            SZ_H:    align_mask = 3'b001;
            SZ_W:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050243_store_align_if.sv
// Store-align bus: LSU request side plus data-memory write side.
// "master" is the surrounding LSU/memory environment, "slave" is the aligner.
interface ysyx_22050243_store_align_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    // Handshake rule on both sides: a transfer happens on a rising clk edge
    // where valid and ready are both 1; the valid side holds its payload
    // stable until that edge, and ready may be observed without valid.
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [ADDR_WIDTH-1:0]   req_addr_i;
    logic [DATA_WIDTH-1:0]   req_data_i;
    logic [1:0]              req_size_i;
    logic                    mem_valid_o;
    logic                    mem_ready_i;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic [DATA_WIDTH/8-1:0] mem_wstrb_o;
    logic                    done_o;
    logic                    misalign_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_size_i, mem_ready_i,
        input  req_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
               done_o, misalign_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_size_i, mem_ready_i,
        output req_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
               done_o, misalign_o
    );

endinterface

// File: rtl/ysyx_22050243_store_lane_gen.sv
// Combinational store lane placement: truncates the operand to its size and
// shifts data and byte strobes across a 16-byte (two-beat) window.
module ysyx_22050243_store_lane_gen
    import ysyx_22050243_lsu_pkg::*;
(
    input  logic [63:0]  data,
    input  logic [1:0]   size,
    input  logic [2:0]   off,
    output logic [127:0] wide,
    output logic [15:0]  strb16
);

    logic [63:0] trunc;

    always_comb begin
        trunc = data;
        case (size_e'(size))
            SZ_B:    trunc = {56'd0, data[7:0]};
            SZ_H:    trunc = {48'd0, data[15:0]};
            SZ_W:    trunc = {32'd0, data[31:0]};
            default: trunc = data;
        endcase
        wide   = {64'd0, trunc} << {off, 3'b000};
        strb16 = {8'd0, size_strb(size)} << off;
    end

endmodule

// File: rtl/ysyx_22050243_store_align.sv
// Store aligner: places a right-justified store operand on its byte lanes and
// splits 8-byte-boundary-crossing stores into two beats.
// Optional YSYX_22050243_STORE_ALIGN_TRAP_EN rejects misaligned stores instead.
module ysyx_22050243_store_align
    import ysyx_22050243_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_22050243_store_align_if.slave bus,
    output state_e dbg_state
);

    state_e state_q, state_d;

    logic [127:0]           wide;
    logic [15:0]            strb16;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [ADDR_WIDTH-1:0]  b0_addr_q, b1_addr_q;
    logic [DATA_WIDTH-1:0]  b0_data_q, b1_data_q;
    logic [STRB_W-1:0]      b0_strb_q, b1_strb_q;
    logic                   split_q, done_q;
    logic                   trap, accept, last_hs;

    ysyx_22050243_store_lane_gen u_lane_gen (
        .data   (bus.req_data_i),
        .size   (bus.req_size_i),
        .off    (bus.req_addr_i[2:0]),
        .wide   (wide),
        .strb16 (strb16)
    );

    assign base_addr = {bus.req_addr_i[ADDR_WIDTH-1:3], 3'b000};

`ifdef YSYX_22050243_STORE_ALIGN_TRAP_EN
    logic misalign_q;
    assign trap = |(bus.req_addr_i[2:0] & align_mask(bus.req_size_i));
    assign bus.misalign_o = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= (state_q == IDLE) && bus.req_valid_i && trap;
    end
`else
    assign trap = 1'b0;
    assign bus.misalign_o = 1'b0;
`endif

    assign accept  = (state_q == IDLE) && bus.req_valid_i && !trap;
    assign last_hs = bus.mem_ready_i &&
                     (((state_q == BEAT0) && !split_q) || (state_q == BEAT1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BEAT0;
            BEAT0:   if (bus.mem_ready_i) state_d = split_q ? BEAT1 : IDLE;
            BEAT1:   if (bus.mem_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Both beats are captured at acceptance so the bus payload is register-driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0_addr_q <= '0;
            b1_addr_q <= '0;
            b0_data_q <= '0;
            b1_data_q <= '0;
            b0_strb_q <= '0;
            b1_strb_q <= '0;
            split_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (accept) begin
                b0_addr_q <= base_addr;
                b1_addr_q <= base_addr + ADDR_WIDTH'(8);
                b0_data_q <= wide[63:0];
                b1_data_q <= wide[127:64];
                b0_strb_q <= strb16[7:0];
                b1_strb_q <= strb16[15:8];
                split_q   <= |strb16[15:8];
            end
        end
    end

    always_comb begin
        bus.req_ready_o = 1'b0;
        bus.mem_valid_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_wstrb_o = '0;
        case (state_q)
            IDLE: bus.req_ready_o = 1'b1;
            BEAT0: begin
                bus.mem_valid_o = 1'b1;
                bus.mem_addr_o  = b0_addr_q;
                bus.mem_wdata_o = b0_data_q;
                bus.mem_wstrb_o = b0_strb_q;
            end
            BEAT1: begin
                bus.mem_valid_o = 1'b1;
                bus.mem_addr_o  = b1_addr_q;
                bus.mem_wdata_o = b1_data_q;
                bus.mem_wstrb_o = b1_strb_q;
            end
            default: bus.req_ready_o = 1'b0;
        endcase
    end

    assign bus.done_o = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ysyx_22050243_store_align.sv
// Bench for ysyx_22050243_store_align: byte-by-byte reference model feeding a
// beat scoreboard, directed scenarios and randomized stores.
module tb_ysyx_22050243_store_align;
    import ysyx_22050243_lsu_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;

    logic   clk = 1'b0;
    logic   rst_n;
    state_e dbg_state;

    always #5 clk = ~clk;

    ysyx_22050243_store_align_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_22050243_store_align #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Expected beats, packed as {addr, wdata, strb}.
    logic [103:0] exp_q[$];

    // Results of the most recent run_store call.
    int beats, cyc;
    bit hold_ok, done_s, mis_s, rdy_s, tmo;

    function automatic bit trap_expected(input logic [31:0] addr, input logic [1:0] size);
        bit mis;
        mis = (addr & ((32'd1 << size) - 32'd1)) != 32'd0;
`ifndef YSYX_22050243_STORE_ALIGN_TRAP_EN
        mis = 1'b0;
`endif
        return mis;
    endfunction

    // Walks the store one byte at a time; every byte lands in the beat of its
    // own 8-byte-aligned address, beats emitted in ascending byte order.
    task automatic model_store(input logic [31:0] addr, input logic [63:0] data,
                               input logic [1:0] size);
        int          n, lane;
        logic [31:0] a, base, cur;
        logic [63:0] wd;
        logic [7:0]  st;
        bit          open;
        n = 1 << size;
        open = 1'b0; wd = '0; st = '0; cur = '0;
        if (trap_expected(addr, size)) return;
        for (int i = 0; i < n; i++) begin
            a    = addr + 32'(i);
            base = a & 32'hFFFF_FFF8;
            lane = int'(a % 8);
            if (open && base != cur) begin
                exp_q.push_back({cur, wd, st});
                wd = '0;
                st = '0;
            end
            cur  = base;
            open = 1'b1;
            wd[lane*8 +: 8] = data[i*8 +: 8];
            st[lane] = 1'b1;
        end
        exp_q.push_back({cur, wd, st});
    endtask

    // Scoreboard: samples 2 time units after each falling edge, well away from
    // the active edge and after the driver has updated mem_ready_i.
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1 && bus.mem_valid_o === 1'b1) begin
            checks++;
            if (bus.done_o !== 1'b0) begin
                errors++;
                $display("FAIL sb_done_during_beat got %b exp 0", bus.done_o);
            end
            if (bus.mem_ready_i === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_beat got addr=%h data=%h strb=%h exp none",
                             bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o);
                end else begin
                    logic [103:0] e;
                    e = exp_q.pop_front();
                    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o} !== e) begin
                        errors++;
                        $display("FAIL sb_beat got addr=%h data=%h strb=%h exp addr=%h data=%h strb=%h",
                                 bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o,
                                 e[103:72], e[71:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_idle();
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = $urandom;
        bus.req_data_i  = {$urandom, $urandom};
        bus.req_size_i  = 2'($urandom_range(0, 3));
        bus.mem_ready_i = 1'b0;
    endtask

    // Called at a falling edge with the block idle; returns at the falling edge
    // where the block is idle again. stall < 0 picks 0..2 wait cycles per beat.
    task automatic run_store(input logic [31:0] addr, input logic [63:0] data,
                             input logic [1:0] size, input int stall);
        logic [103:0] first;
        int           st;
        bit           fin;
        beats = 0; cyc = 0; hold_ok = 1'b1; done_s = 1'b0; mis_s = 1'b0;
        rdy_s = 1'b0; tmo = 1'b1; fin = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_data_i  = data;
        bus.req_size_i  = size;
        bus.mem_ready_i = 1'b0;
        @(negedge clk); cyc++;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = $urandom;
        bus.req_data_i  = {$urandom, $urandom};
        for (int k = 0; k < 8 && !fin; k++) begin
            if (bus.mem_valid_o !== 1'b1) begin
                done_s = bus.done_o;
                mis_s  = bus.misalign_o;
                rdy_s  = bus.req_ready_o;
                tmo    = 1'b0;
                fin    = 1'b1;
            end else begin
                first = {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o};
                st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
                for (int s = 0; s < st; s++) begin
                    @(negedge clk); cyc++;
                    if ({bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o} !== first ||
                        bus.mem_valid_o !== 1'b1)
                        hold_ok = 1'b0;
                end
                bus.mem_ready_i = 1'b1;
                beats++;
                @(negedge clk); cyc++;
                bus.mem_ready_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req_ready_o, bus.mem_valid_o, bus.mem_addr_o, bus.mem_wdata_o,
             bus.mem_wstrb_o, bus.done_o, bus.misalign_o} !== {1'b1, 1'b0, 32'd0, 64'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b a=%h d=%h s=%h done=%b mis=%b exp rdy=1 rest 0",
                     bus.req_ready_o, bus.mem_valid_o, bus.mem_addr_o, bus.mem_wdata_o,
                     bus.mem_wstrb_o, bus.done_o, bus.misalign_o);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One store with model, drive and outcome comparison; name tags FAIL lines.
    task automatic test_store(input string name, input logic [31:0] addr,
                              input logic [63:0] data, input logic [1:0] size, input int stall);
        int nexp;
        bit tr;
        model_store(addr, data, size);
        nexp = exp_q.size();
        tr   = trap_expected(addr, size);
        run_store(addr, data, size, stall);
        checks++;
        if ({tmo, 4'(beats), done_s, rdy_s, mis_s, 4'(exp_q.size())} !==
            {1'b0, 4'(nexp), !tr, 1'b1, tr, 4'd0}) begin
            errors++;
            $display("FAIL %s_outcome got tmo=%b beats=%0d done=%b rdy=%b mis=%b left=%0d exp tmo=0 beats=%0d done=%b rdy=1 mis=%b left=0",
                     name, tmo, beats, done_s, rdy_s, mis_s, exp_q.size(), nexp, !tr, tr);
        end
        exp_q.delete();
    endtask

    task automatic test_sb();
        test_store("sb", 32'h0000_1003, 64'hFFFF_FFFF_FFFF_FFAB, SZ_B, 0);
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        checks++;
        if ({bus.done_o, bus.mem_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL sb_done_width got done=%b valid=%b exp 0 0", bus.done_o, bus.mem_valid_o);
        end
    endtask

    task automatic test_split_sd();
        test_store("sd_split", 32'h0000_1005, 64'h1122_3344_5566_7788, SZ_D, 0);
        test_store("sd_split_stall", 32'h0000_1005, 64'h1122_3344_5566_7788, SZ_D, 2);
    endtask

    task automatic test_stall();
        test_store("sw_stall", 32'h0000_2000, {$urandom, $urandom}, SZ_W, 5);
        checks++;
        if (hold_ok !== 1'b1 || cyc !== 7) begin
            errors++;
            $display("FAIL sw_stall_hold got hold=%b cycles=%0d exp hold=1 cycles=7", hold_ok, cyc);
        end
    endtask

    task automatic test_wrap();
        test_store("sh_wrap", 32'hFFFF_FFFF, {$urandom, $urandom}, SZ_H, 0);
        test_store("sd_wrap", 32'hFFFF_FFFC, {$urandom, $urandom}, SZ_D, 1);
    endtask

    task automatic test_reset_mid();
        model_store(32'h0000_1005, 64'hA1B2_C3D4_E5F6_0718, SZ_D);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_1005;
        bus.req_data_i  = 64'hA1B2_C3D4_E5F6_0718;
        bus.req_size_i  = SZ_D;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        checks++;
        if (dbg_state !== BEAT1 || bus.mem_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre got state=%0d valid=%b exp state=%0d valid=1",
                     dbg_state, bus.mem_valid_o, BEAT1);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_valid_o, bus.req_ready_o, bus.done_o} !== 3'b010 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL rst_mid_abort got valid=%b rdy=%b done=%b state=%0d exp valid=0 rdy=1 done=0 state=%0d",
                     bus.mem_valid_o, bus.req_ready_o, bus.done_o, dbg_state, IDLE);
        end
        checks++;
        if (exp_q.size() !== 1) begin
            errors++;
            $display("FAIL rst_mid_beats got left=%0d exp 1", exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.done_o, bus.mem_valid_o} !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid_after got done=%b valid=%b exp 0 0", bus.done_o, bus.mem_valid_o);
            end
        end
        bus.mem_ready_i = 1'b0;
        test_store("rst_recover", 32'h0000_3004, {$urandom, $urandom}, SZ_W, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            test_store("b2b", {$urandom_range(0, 32'hFFFF), 3'b000} , {$urandom, $urandom},
                       (i % 2 == 0) ? SZ_D : SZ_W, 0);
            checks++;
            if (cyc !== 2) begin
                errors++;
                $display("FAIL b2b_cycles got %0d exp 2", cyc);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [1:0]  size;
        int          gap;
        for (int i = 0; i < 150; i++) begin
            size = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
                1:       addr = $urandom & ~((32'd1 << size) - 32'd1);
                default: addr = $urandom;
            endcase
            test_store("rand", addr, {$urandom, $urandom}, size, -1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.mem_ready_i = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++;
                if ({bus.done_o, bus.misalign_o, bus.mem_valid_o, bus.req_ready_o} !== 4'b0001) begin
                    errors++;
                    $display("FAIL rand_gap got done=%b mis=%b valid=%b rdy=%b exp 0 0 0 1",
                             bus.done_o, bus.misalign_o, bus.mem_valid_o, bus.req_ready_o);
                end
            end
            bus.mem_ready_i = 1'b0;
        end
    endtask

`ifdef YSYX_22050243_STORE_ALIGN_TRAP_EN
    task automatic test_trap();
        test_store("trap_sw", 32'h0000_1002, {$urandom, $urandom}, SZ_W, 0);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL trap_cycles got %0d exp 1", cyc);
        end
        test_store("trap_next", 32'h0000_1004, {$urandom, $urandom}, SZ_W, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_sb();
        test_split_sd();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef YSYX_22050243_STORE_ALIGN_TRAP_EN
        test_trap();
`endif
        test_random();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
